// File: rtl/gcn_fetch_ctrl.sv
// gcn_fetch_ctrl
// Read-side initiator for the GCN row memory. Walks the weight rows, then the
// feature rows, then the COO edge list, and hands each item downstream over a
// valid/ready handshake. Every item costs one fetch cycle plus at least one
// hold cycle, so a fetch never overlaps a pending hold.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low
//   start          level; only sampled while idle
//   read_address   row-memory address (holds its value outside fetch cycles)
//   enable_read    one-cycle read strobe per row
//   data_in        row returned combinationally for read_address
//   row_data       captured row
//   row_valid      row_data/row_index/row_is_feature valid
//   row_ready      downstream accepts the row
//   row_is_feature 0 = weight row, 1 = feature row
//   row_index      row number within its bank
//   coo_address    edge-list column (holds its value outside fetch cycles)
//   coo_in         {src, dst} for coo_address
//   edge_src/dst   captured edge
//   edge_valid     edge valid
//   edge_ready     downstream accepts the edge
//   done           every item delivered
module gcn_fetch_ctrl #(
  parameter int WEIGHT_ROWS     = 96,
  parameter int WEIGHT_COLS     = 3,
  parameter int FEATURE_ROWS    = 6,
  parameter int WEIGHT_WIDTH    = 5,
  parameter int ADDRESS_WIDTH   = 13,
  parameter logic [ADDRESS_WIDTH-1:0] FEATURE_BASE = 'h200,
  parameter int COO_NUM_OF_COLS = 6,
  parameter int COO_BW          = $clog2(COO_NUM_OF_COLS),
  parameter int IDX_W           = $clog2((WEIGHT_COLS > FEATURE_ROWS) ? WEIGHT_COLS : FEATURE_ROWS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  output logic                     enable_read,
  input  logic [WEIGHT_WIDTH-1:0]  data_in [0:WEIGHT_ROWS-1],
  output logic [WEIGHT_WIDTH-1:0]  row_data [0:WEIGHT_ROWS-1],
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic                     row_is_feature,
  output logic [IDX_W-1:0]         row_index,
  output logic [COO_BW-1:0]        coo_address,
  input  logic [2*COO_BW-1:0]      coo_in,
  output logic [COO_BW-1:0]        edge_src,
  output logic [COO_BW-1:0]        edge_dst,
  output logic                     edge_valid,
  input  logic                     edge_ready,
  output logic                     done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH_W = 3'd1;
  localparam logic [2:0] HOLD_W  = 3'd2;
  localparam logic [2:0] FETCH_F = 3'd3;
  localparam logic [2:0] HOLD_F  = 3'd4;
  localparam logic [2:0] FETCH_E = 3'd5;
  localparam logic [2:0] HOLD_E  = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  // One counter serves all three walks, so it must cover both index widths.
  localparam int CNT_W = (IDX_W > COO_BW) ? IDX_W : COO_BW;

  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WEIGHT_COLS - 1);
  localparam logic [CNT_W-1:0] F_LAST = CNT_W'(FEATURE_ROWS - 1);
  localparam logic [CNT_W-1:0] E_LAST = CNT_W'(COO_NUM_OF_COLS - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = counter + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      counter        <= '0;
      read_address   <= '0;
      enable_read    <= 1'b0;
      row_data       <= '{default: '0};
      row_valid      <= 1'b0;
      row_is_feature <= 1'b0;
      row_index      <= '0;
      coo_address    <= '0;
      edge_src       <= '0;
      edge_dst       <= '0;
      edge_valid     <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            counter      <= '0;
            read_address <= '0;
            enable_read  <= 1'b1;
            state        <= FETCH_W;
          end
        end

        // Fetch -> hold boundary: the zero-wait row is captured on the edge
        // that ends the read strobe.
        FETCH_W, FETCH_F: begin
          row_data       <= data_in;
          row_index      <= counter[IDX_W-1:0];
          row_is_feature <= (state == FETCH_F);
          row_valid      <= 1'b1;
          enable_read    <= 1'b0;
          state          <= (state == FETCH_F) ? HOLD_F : HOLD_W;
        end

        // Hold -> next fetch boundary: nothing moves until the row is taken.
        HOLD_W: begin
          if (row_ready) begin
            row_valid   <= 1'b0;
            enable_read <= 1'b1;
            if (counter == W_LAST) begin
              counter      <= '0;
              read_address <= FEATURE_BASE;
              state        <= FETCH_F;
            end else begin
              counter      <= cnt_inc;
              read_address <= ADDRESS_WIDTH'(cnt_inc);
              state        <= FETCH_W;
            end
          end
        end

        HOLD_F: begin
          if (row_ready) begin
            row_valid <= 1'b0;
            if (counter == F_LAST) begin
              counter     <= '0;
              coo_address <= '0;
              state       <= FETCH_E;
            end else begin
              counter      <= cnt_inc;
              read_address <= FEATURE_BASE + ADDRESS_WIDTH'(cnt_inc);
              enable_read  <= 1'b1;
              state        <= FETCH_F;
            end
          end
        end

        // Edge fetch -> hold boundary: coo_in upper half is the source node.
        FETCH_E: begin
          edge_src   <= coo_in[2*COO_BW-1:COO_BW];
          edge_dst   <= coo_in[COO_BW-1:0];
          edge_valid <= 1'b1;
          state      <= HOLD_E;
        end

        HOLD_E: begin
          if (edge_ready) begin
            edge_valid <= 1'b0;
            if (counter == E_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              counter     <= cnt_inc;
              coo_address <= cnt_inc[COO_BW-1:0];
              state       <= FETCH_E;
            end
          end
        end

        // A held-high start must not relaunch the walk.
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcn_fetch_ctrl.sv
module tb_gcn_fetch_ctrl;
  localparam int WR = 96;
  localparam int WC = 3;
  localparam int FR = 6;
  localparam int WW = 5;
  localparam int AW = 13;
  localparam int CN = 6;
  localparam int CB = 3;
  localparam int IW = 3;
  localparam logic [AW-1:0] FBASE = 13'h200;

  logic clk = 1'b0;
  logic reset, start, row_ready, edge_ready;
  logic [AW-1:0] read_address;
  logic enable_read;
  logic [WW-1:0] data_in [0:WR-1];
  logic [WW-1:0] row_data [0:WR-1];
  logic row_valid, row_is_feature, edge_valid, done;
  logic [IW-1:0] row_index;
  logic [CB-1:0] coo_address, edge_src, edge_dst;
  logic [2*CB-1:0] coo_in;

  int checks = 0;
  int errors = 0;
  int salt = 0;
  logic [CB-1:0] coo_src [0:7];
  logic [CB-1:0] coo_dst [0:7];

  typedef struct {
    bit            is_edge;
    logic [AW-1:0] addr;
    bit            feat;
    logic [IW-1:0] idx;
    logic [CB-1:0] src;
    logic [CB-1:0] dst;
  } item_t;

  gcn_fetch_ctrl #(
    .WEIGHT_ROWS(WR), .WEIGHT_COLS(WC), .FEATURE_ROWS(FR), .WEIGHT_WIDTH(WW),
    .ADDRESS_WIDTH(AW), .FEATURE_BASE(FBASE), .COO_NUM_OF_COLS(CN),
    .COO_BW(CB), .IDX_W(IW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .read_address(read_address), .enable_read(enable_read),
    .data_in(data_in), .row_data(row_data), .row_valid(row_valid),
    .row_ready(row_ready), .row_is_feature(row_is_feature), .row_index(row_index),
    .coo_address(coo_address), .coo_in(coo_in), .edge_src(edge_src),
    .edge_dst(edge_dst), .edge_valid(edge_valid), .edge_ready(edge_ready),
    .done(done)
  );

  always #5 clk = ~clk;

  // Zero-wait responder: element j of the row at addr is (addr + j + salt) mod 32.
  always_comb begin
    for (int j = 0; j < WR; j++)
      data_in[j] = WW'((int'(read_address) + j + salt) % 32);
  end
  assign coo_in = {coo_src[coo_address], coo_dst[coo_address]};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit row_ok(input int addr);
    for (int j = 0; j < WR; j++)
      if (row_data[j] !== WW'((addr + j + salt) % 32)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit outs_zero();
    bit z;
    z = (read_address === '0) && (enable_read === 1'b0) && (row_valid === 1'b0) &&
        (row_is_feature === 1'b0) && (row_index === '0) && (coo_address === '0) &&
        (edge_src === '0) && (edge_dst === '0) && (edge_valid === 1'b0) && (done === 1'b0);
    for (int j = 0; j < WR; j++)
      if (row_data[j] !== '0) z = 1'b0;
    return z;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake-level invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ((row_valid && edge_valid) || (done && (row_valid || edge_valid))) begin
        errors++;
        $display("FAIL valid_exclusive: row_valid=%0b edge_valid=%0b done=%0b", row_valid, edge_valid, done);
      end
    end
  end

  // Reference walk built from the item order rules, then driven with random
  // (or forced) backpressure. Payload is compared every cycle it is valid, which
  // also proves it stays stable while stalled.
  task automatic run_seq(input int rdy_pct, input int stall_item, input int stall_len, input bit chk_lat);
    item_t q[$];
    logic [AW-1:0] aq[$];
    item_t it;
    logic [AW-1:0] last_addr;
    int cyc, n_acc, stall_cnt;
    bit rdy, fin;
    for (int i = 0; i < WC; i++) begin
      it = '{1'b0, AW'(i), 1'b0, IW'(i), '0, '0};
      q.push_back(it); aq.push_back(AW'(i));
    end
    for (int i = 0; i < FR; i++) begin
      it = '{1'b0, FBASE + AW'(i), 1'b1, IW'(i), '0, '0};
      q.push_back(it); aq.push_back(FBASE + AW'(i));
    end
    for (int e = 0; e < CN; e++) begin
      it = '{1'b1, '0, 1'b0, IW'(e), coo_src[e], coo_dst[e]};
      q.push_back(it);
    end
    n_acc = 0; stall_cnt = 0; fin = 1'b0; last_addr = '0; cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (!fin && cyc < 400) begin
      if (enable_read) begin
        if (aq.size() == 0) chk("extra_fetch", 1, 0);
        else begin
          chk("fetch_addr", read_address, aq[0]);
          last_addr = aq.pop_front();
        end
        chk("fetch_overlap", row_valid | edge_valid, 0);
      end
      rdy = 1'b0;
      if (row_valid || edge_valid) begin
        if (q.size() == 0) chk("extra_item", 1, 0);
        else begin
          if (!q[0].is_edge) begin
            chk("kind_row", row_valid, 1);
            chk("row_feat", row_is_feature, q[0].feat);
            chk("row_idx", row_index, q[0].idx);
            chk("row_data", row_ok(int'(q[0].addr)), 1);
            chk("hold_addr", read_address, last_addr);
          end else begin
            chk("kind_edge", edge_valid, 1);
            chk("hold_coo_addr", coo_address, q[0].idx);
            chk("edge_src", edge_src, q[0].src);
            chk("edge_dst", edge_dst, q[0].dst);
          end
          if (n_acc == stall_item && stall_cnt < stall_len) stall_cnt++;
          else rdy = ($urandom_range(99) < rdy_pct);
          if (rdy) begin
            void'(q.pop_front());
            n_acc++;
          end
        end
      end
      row_ready = rdy;
      edge_ready = rdy;
      if (done) begin
        chk("items_left", q.size(), 0);
        chk("fetches_left", aq.size(), 0);
        if (chk_lat) chk("done_latency", cyc, 30);
        fin = 1'b1;
      end else begin
        step();
        cyc++;
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    if (stall_len > 0) chk("stall_applied", stall_cnt, stall_len);
    start = 1'b0;
    step();
    chk("done_clear", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    item_t vec [0:14];
    int c;
    vec[0]  = '{1'b0, 13'h000, 1'b0, 3'd0, 3'd0, 3'd0};
    vec[1]  = '{1'b0, 13'h001, 1'b0, 3'd1, 3'd0, 3'd0};
    vec[2]  = '{1'b0, 13'h002, 1'b0, 3'd2, 3'd0, 3'd0};
    vec[3]  = '{1'b0, 13'h200, 1'b1, 3'd0, 3'd0, 3'd0};
    vec[4]  = '{1'b0, 13'h201, 1'b1, 3'd1, 3'd0, 3'd0};
    vec[5]  = '{1'b0, 13'h202, 1'b1, 3'd2, 3'd0, 3'd0};
    vec[6]  = '{1'b0, 13'h203, 1'b1, 3'd3, 3'd0, 3'd0};
    vec[7]  = '{1'b0, 13'h204, 1'b1, 3'd4, 3'd0, 3'd0};
    vec[8]  = '{1'b0, 13'h205, 1'b1, 3'd5, 3'd0, 3'd0};
    vec[9]  = '{1'b1, 13'h000, 1'b0, 3'd0, 3'd0, 3'd1};
    vec[10] = '{1'b1, 13'h000, 1'b0, 3'd1, 3'd1, 3'd2};
    vec[11] = '{1'b1, 13'h000, 1'b0, 3'd2, 3'd2, 3'd3};
    vec[12] = '{1'b1, 13'h000, 1'b0, 3'd3, 3'd3, 3'd4};
    vec[13] = '{1'b1, 13'h000, 1'b0, 3'd4, 3'd4, 3'd5};
    vec[14] = '{1'b1, 13'h000, 1'b0, 3'd5, 3'd5, 3'd0};
    for (int i = 0; i < 8; i++) begin
      coo_src[i] = CB'(i % CN);
      coo_dst[i] = CB'((i + 1) % CN);
    end

    // Reset asserted mid-cycle, released with start low.
    reset = 1'b1; start = 1'b0; row_ready = 1'b0; edge_ready = 1'b0;
    #2 reset = 1'b0;
    #1 chk("reset_outputs", outs_zero(), 1);
    step();
    @(negedge clk) reset = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_no_read", enable_read, 0);
    end
    chk("idle_outputs", outs_zero(), 1);

    // Full sweep with ready tied high, applied from the vector table.
    row_ready = 1'b1; edge_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (!vec[i].is_edge) begin
        chk("tbl_fetch_en", enable_read, 1);
        chk("tbl_fetch_addr", read_address, vec[i].addr);
        step();
        chk("tbl_row_valid", row_valid, 1);
        chk("tbl_row_feat", row_is_feature, vec[i].feat);
        chk("tbl_row_idx", row_index, vec[i].idx);
        chk("tbl_row_data", row_ok(int'(vec[i].addr)), 1);
        step();
      end else begin
        chk("tbl_coo_addr", coo_address, vec[i].idx);
        chk("tbl_edge_no_read", enable_read, 0);
        step();
        chk("tbl_edge_valid", edge_valid, 1);
        chk("tbl_edge_src", edge_src, vec[i].src);
        chk("tbl_edge_dst", edge_dst, vec[i].dst);
        step();
      end
    end
    chk("tbl_done_k30", done, 1);

    // start held high in DONE must not restart the walk.
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("done_hold", done, 1);
      chk("done_no_read", enable_read, 0);
    end
    start = 1'b0;
    step();
    chk("done_release", done, 0);
    step();

    // Backpressure on weight row 1 (5 cycles), then on edge 2 (3 cycles).
    run_seq(100, 1, 5, 1'b0);
    run_seq(100, 11, 3, 1'b0);

    // Reset in the middle of HOLD_F for feature row 3.
    row_ready = 1'b1; edge_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    c = 0;
    while (!(row_valid && row_is_feature && row_index == 3) && c < 100) begin
      step();
      c++;
    end
    chk("reach_hold_f3", row_valid && row_is_feature && row_index == 3, 1);
    #3 reset = 1'b0;
    #1 chk("midop_reset_clear", outs_zero(), 1);
    step();
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_idle", enable_read | row_valid | edge_valid | done, 0);
    end
    run_seq(100, -1, 0, 1'b1);

    // Randomized payload, edge list and backpressure.
    for (int r = 0; r < 4; r++) begin
      salt = int'($urandom_range(31));
      for (int i = 0; i < 8; i++) begin
        coo_src[i] = CB'($urandom_range(7));
        coo_dst[i] = CB'($urandom_range(7));
      end
      run_seq(30 + 15 * r, int'($urandom_range(14)), int'($urandom_range(4)), 1'b0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcn_fetch_ctrl.md
# gcn_fetch_ctrl

Read-side initiator for the GCN row-memory interface. It walks the weight bank, the feature bank and the COO edge list, and hands each fetched item downstream over a valid/ready handshake. It sits between the zero-wait row memory and the GCN compute datapath. It owns `read_address`/`enable_read` and `coo_address`, and asserts `done` once every item has been delivered.

## Interface
- WEIGHT_ROWS, 96, elements per fetched row
- WEIGHT_COLS, 3, weight rows fetched, at addresses 0..WEIGHT_COLS-1
- FEATURE_ROWS, 6, feature rows fetched, at FEATURE_BASE+0..FEATURE_ROWS-1
- WEIGHT_WIDTH, 5, element width
- ADDRESS_WIDTH, 13, read address width
- FEATURE_BASE, 13'h200, first feature-row address
- COO_NUM_OF_COLS, 6, number of edges
- COO_BW, $clog2(COO_NUM_OF_COLS), node-index width
- IDX_W, $clog2(max(WEIGHT_COLS,FEATURE_ROWS)), row index width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 resets immediately
- start  in  1  level; sampled in IDLE only
- read_address  out  ADDRESS_WIDTH  row-memory address
- enable_read  out  1  read strobe, one cycle per row
- data_in  in  WEIGHT_WIDTH x [0:WEIGHT_ROWS-1]  row returned combinationally for read_address
- row_data  out  WEIGHT_WIDTH x [0:WEIGHT_ROWS-1]  captured row
- row_valid  out  1  row_data/row_index/row_is_feature valid
- row_ready  in  1  downstream accepts the row
- row_is_feature  out  1  0 = weight row, 1 = feature row
- row_index  out  IDX_W  row number within its bank
- coo_address  out  COO_BW  edge-list column
- coo_in  in  2*COO_BW  {src (COO row 0), dst (COO row 1)} for coo_address
- edge_src, edge_dst  out  COO_BW each  captured edge
- edge_valid  out  1  edge valid
- edge_ready  in  1  downstream accepts the edge
- done  out  1  all items delivered

## Operation
- States: IDLE, FETCH_W, HOLD_W, FETCH_F, HOLD_F, FETCH_E, HOLD_E, DONE.
- IDLE: if start=1 → FETCH_W, counter = 0.
- FETCH_W (1 cycle): read_address = counter, enable_read = 1. At the edge, data_in → row_data, row_index = counter, row_is_feature = 0 → HOLD_W.
- HOLD_W: row_valid = 1, enable_read = 0.
  - On row_valid && row_ready: if counter = WEIGHT_COLS-1 → FETCH_F with counter = 0; else counter+1 → FETCH_W.
- FETCH_F / HOLD_F: same as FETCH_W / HOLD_W, with these differences:
  - read_address = FEATURE_BASE + counter, row_is_feature = 1.
  - The last row goes to FETCH_E.
- FETCH_E (1 cycle): coo_address = counter. At the edge, coo_in → {edge_src, edge_dst} → HOLD_E.
- HOLD_E: edge_valid = 1.
  - On handshake: if counter = COO_NUM_OF_COLS-1 → DONE; else counter+1 → FETCH_E.
- DONE: done = 1. Leave for IDLE only when start = 0.
- start is ignored outside IDLE.
- Address arithmetic is unsigned ADDRESS_WIDTH bits with no wrap; the feature base is added, never ORed.
- read_address and coo_address hold their last value outside the FETCH states.

## Timing
- Reset values: all outputs 0 (read_address, enable_read, row_data, row_valid, row_is_feature, row_index, coo_address, edge_src, edge_dst, edge_valid, done); state IDLE.
- The responder is zero-wait: data_in is sampled on the same edge that ends the enable_read cycle.
- Latency: start sampled at edge k → enable_read high during k..k+1 → row_valid rises after edge k+1.
- Minimum of 2 cycles per row/edge; no fetch is overlapped with a pending hold.
- With ready tied high, done rises after edge k+30 for the default parameters.
- Backpressure: while valid && !ready, all payload outputs stay stable, there is no enable_read pulse and addresses do not change.
- row_valid and edge_valid never go high at the same time. done is a state decode and is never high while any valid is high.
- Reset mid-operation clears all outputs asynchronously. After release the block waits in IDLE for start.

## Test plan
- Reset: drive reset = 0 mid-cycle → all outputs 0 immediately. Release with start = 0 → enable_read stays 0 for 10 cycles.
- Full sweep, ready = 1: pulse start → enable_read pulses with read_address 0,1,2,0x200..0x205, then coo_address 0..5. Expect 9 rows, 6 edges, and done after edge k+30.
- Row payload check:
  - Stimulus: responder returns element j = (addr+j) mod 32.
  - Required: row_data matches; row_index runs 0..2 with row_is_feature = 0, then 0..5 with row_is_feature = 1.
- Backpressure: hold row_ready = 0 for 5 cycles on weight row 1 → row_valid stays 1, row_data is stable, no enable_read pulse, read_address stays 1. Delivery resumes when ready = 1.
- Edges: COO row 0 = {0,1,2,3,4,5}, row 1 = {1,2,3,4,5,0} → edges (0,1)(1,2)(2,3)(3,4)(4,5)(5,0) in order. Stall edge 2 for 3 cycles → its values are held.
- Mid-operation reset during HOLD_F, feature row 3 → outputs cleared. Then start again → first address is 0 and the full sequence repeats. Holding start high while in DONE does not restart the block.
